mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mips_ctrl_pkg.sv | 82 ++++++++
 rtl/mc_decode.sv | 41 ++++
 rtl/mc_control.sv | 191 +++++++++++++++++++
 tb/tb_mc_control.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// datapath select codes and the control bundle driven by mc_control.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_MEM = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_WB_ALU = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'h08;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_LUI   = 3'd5;

    localparam logic [SEL_W-1:0] SRCB_REG    = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [SEL_W-1:0] DST_RT  = 2'd0;
    localparam logic [SEL_W-1:0] DST_RD  = 2'd1;
    localparam logic [SEL_W-1:0] DST_R31 = 2'd2;

    localparam logic [SEL_W-1:0] PC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'd2;

    typedef struct packed {
        logic                pc_we;
        logic                ir_we;
        logic                mem_rd;
        logic                mem_wr;
        logic                iord;
        logic                reg_we;
        logic                mem_to_reg;
        logic                alu_src_a;
        logic [SEL_W-1:0]    alu_src_b;
        logic [SEL_W-1:0]    reg_dst;
        logic [SEL_W-1:0]    pc_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                illegal;
        logic                err_timeout;
    } ctrl_t;

    // Logical immediates (andi/ori) take a zero-extended operand.
    function automatic logic is_zero_ext(input logic [OP_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Opcode decode for mc_control: DECODE/ADDR successors, legality,
// immediate extension select and the EXEC_I ALU operation.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]     opcode,
    output state_t              decode_next_c,
    output state_t              addr_next_c,
    output logic                legal_c,
    output logic                ext_sign_c,
    output logic [ALU_OP_W-1:0] exec_i_alu_op_c
);

    always_comb begin
        decode_next_c   = S_FETCH;
        legal_c         = 1'b1;
        exec_i_alu_op_c = ALU_ADD;
        case (opcode)
            OP_RTYPE:                                   decode_next_c = S_EXEC_R;
            OP_LW, OP_SW:                               decode_next_c = S_ADDR;
            OP_BEQ, OP_BNE:                             decode_next_c = S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: decode_next_c = S_EXEC_I;
            OP_J, OP_JAL:                               decode_next_c = S_JUMP;
            default: begin
                decode_next_c = S_FETCH;
                legal_c       = 1'b0;
            end
        endcase
        case (opcode)
            OP_ANDI: exec_i_alu_op_c = ALU_AND;
            OP_ORI:  exec_i_alu_op_c = ALU_OR;
            OP_LUI:  exec_i_alu_op_c = ALU_LUI;
            default: exec_i_alu_op_c = ALU_ADD;
        endcase
    end

    // ADDR is only reachable from lw/sw, so anything but sw is a load.
    assign addr_next_c = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
    assign ext_sign_c  = ~is_zero_ext(opcode);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM with memory-wait handshake,
// optional wait timeout and illegal-opcode reporting.
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_we,
    output logic                ir_we,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                iord,
    output logic                reg_we,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    reg_dst,
    output logic [SEL_W-1:0]    pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ext_sign,
    output logic                illegal,
    output logic                err_timeout,
    output logic [STATE_W-1:0]  state
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 2);

    state_t                cur_state;
    state_t                next_state;
    logic [CNT_W-1:0]      wait_cnt;
    ctrl_t                 ctrl;

    state_t                decode_next_c;
    state_t                addr_next_c;
    logic                  legal_c;
    logic                  ext_sign_c;
    logic [ALU_OP_W-1:0]   exec_i_alu_op_c;
    logic                  mem_state_c;
    logic                  timeout_c;
    logic                  is_rtype_c;

    mc_decode u_decode (
        .opcode          (opcode),
        .decode_next_c   (decode_next_c),
        .addr_next_c     (addr_next_c),
        .legal_c         (legal_c),
        .ext_sign_c      (ext_sign_c),
        .exec_i_alu_op_c (exec_i_alu_op_c)
    );

    assign is_rtype_c  = (opcode == OP_RTYPE);
    assign mem_state_c = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                         (cur_state == S_MEM_WR);
    assign timeout_c   = (MEM_TIMEOUT != 0) && mem_state_c &&
                         (wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= S_FETCH;
        else     cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (timeout_c)      next_state = S_FETCH;
                else if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: next_state = decode_next_c;
            S_ADDR:   next_state = addr_next_c;
            S_MEM_RD: begin
                if (timeout_c)      next_state = S_FETCH;
                else if (mem_ready) next_state = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (timeout_c || mem_ready) next_state = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I:                     next_state = S_WB_ALU;
            S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP:   next_state = S_FETCH;
            default:                                next_state = S_FETCH;
        endcase
    end

    // Memory wait counter; saturates so a disabled timeout never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((next_state != cur_state) || timeout_c) begin
            wait_cnt <= '0;
        end else if (mem_state_c && !mem_ready && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Everything defaults low; reset holds the whole bundle quiet.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    ctrl.mem_rd      = ~timeout_c;
                    ctrl.ir_we       = mem_ready & ~timeout_c;
                    ctrl.pc_we       = mem_ready & ~timeout_c;
                    ctrl.alu_src_b   = SRCB_FOUR;
                    ctrl.alu_op      = ALU_ADD;
                    ctrl.pc_src      = PC_ALU;
                    ctrl.err_timeout = timeout_c;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.illegal   = ~legal_c;
                end
                S_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_RD: begin
                    ctrl.iord        = 1'b1;
                    ctrl.mem_rd      = ~timeout_c;
                    ctrl.err_timeout = timeout_c;
                end
                S_MEM_WR: begin
                    ctrl.iord        = 1'b1;
                    ctrl.mem_wr      = ~timeout_c;
                    ctrl.err_timeout = timeout_c;
                end
                S_WB_MEM: begin
                    ctrl.reg_we     = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_dst    = DST_RT;
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = exec_i_alu_op_c;
                end
                S_WB_ALU: begin
                    ctrl.reg_we  = ~(is_rtype_c && (funct == FUNCT_JR));
                    ctrl.reg_dst = is_rtype_c ? DST_RD : DST_RT;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = PC_ALUOUT;
                    ctrl.pc_we     = zero ^ (opcode == OP_BNE);
                end
                S_JUMP: begin
                    ctrl.pc_src = PC_JUMP;
                    ctrl.pc_we  = 1'b1;
                    if (opcode == OP_JAL) begin
                        ctrl.reg_we  = 1'b1;
                        ctrl.reg_dst = DST_R31;
                    end
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ir_we       = ctrl.ir_we;
    assign mem_rd      = ctrl.mem_rd;
    assign mem_wr      = ctrl.mem_wr;
    assign iord        = ctrl.iord;
    assign reg_we      = ctrl.reg_we;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign reg_dst     = ctrl.reg_dst;
    assign pc_src      = ctrl.pc_src;
    assign alu_op      = ctrl.alu_op;
    assign illegal     = ctrl.illegal;
    assign err_timeout = ctrl.err_timeout;
    assign ext_sign    = ext_sign_c;
    assign state       = cur_state;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-instruction cycle traces from an
// instruction-level model, directed corner cases, then random programs.
module tb_mc_control;
    import mips_ctrl_pkg::*;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, reg_dst, pc_src;
    logic [2:0] alu_op;
    logic       ext_sign, illegal, err_timeout;
    logic [3:0] state;

    mc_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .iord(iord), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
        .pc_src(pc_src), .alu_op(alu_op), .ext_sign(ext_sign), .illegal(illegal),
        .err_timeout(err_timeout), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, reg_dst, pc_src;
        logic [2:0] alu_op;
        logic       ext_sign, illegal, err_timeout;
    } obs_t;

    typedef struct {
        obs_t o;
        logic mr;
    } step_t;

    typedef struct {
        int ncyc;
        int nregwe;
        int npcwe;
        int nto;
        int nill;
    } cnt_t;

    step_t trace[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state;           o.pc_we = pc_we;         o.ir_we = ir_we;
        o.mem_rd = mem_rd;      o.mem_wr = mem_wr;       o.iord = iord;
        o.reg_we = reg_we;      o.mem_to_reg = mem_to_reg;
        o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.reg_dst = reg_dst;
        o.pc_src = pc_src;      o.alu_op = alu_op;       o.ext_sign = ext_sign;
        o.illegal = illegal;    o.err_timeout = err_timeout;
        return o;
    endfunction

    function automatic obs_t blank(input state_t s, input logic [5:0] op);
        obs_t o = '0;
        o.st       = s;
        o.ext_sign = !(op == 6'h0C || op == 6'h0D);
        return o;
    endfunction

    task automatic push(input obs_t o, input logic mr);
        step_t s;
        s.o  = o;
        s.mr = mr;
        trace.push_back(s);
    endtask

    // A memory phase: stalls with mem_ready low, then either completion or a timeout.
    task automatic mem_phase(input obs_t busy, input obs_t done, input int stalls, output bit aborted);
        obs_t t;
        for (int i = 0; i < stalls && i < int'(TO); i++) push(busy, 1'b0);
        if (stalls >= int'(TO)) begin
            t = busy;
            t.mem_rd = 1'b0;
            t.mem_wr = 1'b0;
            t.err_timeout = 1'b1;
            push(t, 1'b0);
            aborted = 1'b1;
        end else begin
            push(done, 1'b1);
            aborted = 1'b0;
        end
    endtask

    // Instruction-level model: expected cycle-by-cycle behaviour of one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int sf, input int sm);
        obs_t b, d;
        bit   ab;
        logic legal;
        trace.delete();
        b = blank(S_FETCH, op);
        b.mem_rd = 1'b1;
        b.alu_src_b = 2'd1;
        d = b;
        d.ir_we = 1'b1;
        d.pc_we = 1'b1;
        mem_phase(b, d, sf, ab);
        if (ab) return;
        legal = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09,
                           6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03};
        b = blank(S_DECODE, op);
        b.alu_src_b = 2'd3;
        b.illegal = !legal;
        push(b, 1'($urandom_range(0, 1)));
        if (!legal) return;
        if (op == 6'h00 || op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F}) begin
            b = blank(op == 6'h00 ? S_EXEC_R : S_EXEC_I, op);
            b.alu_src_a = 1'b1;
            b.alu_src_b = (op == 6'h00) ? 2'd0 : 2'd2;
            b.alu_op = (op == 6'h00) ? 3'd2 : (op == 6'h0C) ? 3'd3 :
                       (op == 6'h0D) ? 3'd4 : (op == 6'h0F) ? 3'd5 : 3'd0;
            push(b, 1'($urandom_range(0, 1)));
            b = blank(S_WB_ALU, op);
            b.reg_we = !(op == 6'h00 && fn == 6'h08);
            b.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0;
            push(b, 1'($urandom_range(0, 1)));
        end else if (op == 6'h23 || op == 6'h2B) begin
            b = blank(S_ADDR, op);
            b.alu_src_a = 1'b1;
            b.alu_src_b = 2'd2;
            push(b, 1'($urandom_range(0, 1)));
            b = blank(op == 6'h23 ? S_MEM_RD : S_MEM_WR, op);
            b.iord = 1'b1;
            b.mem_rd = (op == 6'h23);
            b.mem_wr = (op == 6'h2B);
            mem_phase(b, b, sm, ab);
            if (!ab && op == 6'h23) begin
                b = blank(S_WB_MEM, op);
                b.reg_we = 1'b1;
                b.mem_to_reg = 1'b1;
                push(b, 1'($urandom_range(0, 1)));
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            b = blank(S_BRANCH, op);
            b.alu_src_a = 1'b1;
            b.alu_op = 3'd1;
            b.pc_src = 2'd1;
            b.pc_we = (op == 6'h04) ? z : !z;
            push(b, 1'($urandom_range(0, 1)));
        end else begin
            b = blank(S_JUMP, op);
            b.pc_src = 2'd2;
            b.pc_we = 1'b1;
            if (op == 6'h03) begin
                b.reg_we = 1'b1;
                b.reg_dst = 2'd2;
            end
            push(b, 1'($urandom_range(0, 1)));
        end
    endtask

    // Called at a falling edge; returns at a falling edge (or at the abort point).
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int sf, input int sm, input int abort_at,
                             output cnt_t c);
        obs_t got;
        build(op, fn, z, sf, sm);
        c = '{0, 0, 0, 0, 0};
        foreach (trace[i]) begin
            if (abort_at >= 0 && i >= abort_at) break;
            opcode = op;
            funct = fn;
            zero = z;
            mem_ready = trace[i].mr;
            #1;
            got = sample();
            check($sformatf("%s_c%0d", tag, i), 32'(got), 32'(trace[i].o));
            c.ncyc++;
            c.nregwe += int'(got.reg_we);
            c.npcwe  += int'(got.pc_we);
            c.nto    += int'(got.err_timeout);
            c.nill   += int'(got.illegal);
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] strobes();
        return 32'({pc_we, ir_we, mem_rd, mem_wr, reg_we, illegal, err_timeout});
    endfunction

    logic [5:0] ops [15] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09,
                             6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h3F, 6'h11};

    initial begin
        cnt_t c;
        int   sf, sm;
        logic [5:0] fn;

        // Reset: FETCH, no strobes even with mem_ready high.
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'(S_FETCH));
        check("rst_strobes", strobes(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_instr("lw_stall3", 6'h23, 6'h00, 1'b0, 0, 3, -1, c);
        check("lw_stall3_cycles", 32'(c.ncyc), 32'd8);
        check("lw_stall3_regwe", 32'(c.nregwe), 32'd1);

        run_instr("lw", 6'h23, 6'h00, 1'b0, 0, 0, -1, c);
        check("lw_cycles", 32'(c.ncyc), 32'd5);
        run_instr("sw", 6'h2B, 6'h00, 1'b0, 0, 0, -1, c);
        check("sw_cycles", 32'(c.ncyc), 32'd4);
        check("sw_regwe", 32'(c.nregwe), 32'd0);

        run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, -1, c);
        check("beq_cycles", 32'(c.ncyc), 32'd3);
        check("beq_pcwe", 32'(c.npcwe), 32'd2);
        run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, -1, c);
        check("bne_cycles", 32'(c.ncyc), 32'd3);
        check("bne_pcwe", 32'(c.npcwe), 32'd1);

        run_instr("ori", 6'h0D, 6'h00, 1'b0, 0, 0, -1, c);
        check("ori_cycles", 32'(c.ncyc), 32'd4);
        run_instr("addi", 6'h08, 6'h00, 1'b0, 0, 0, -1, c);
        check("addi_cycles", 32'(c.ncyc), 32'd4);
        run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0, -1, c);
        check("rtype_cycles", 32'(c.ncyc), 32'd4);
        run_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0, -1, c);
        check("jr_regwe", 32'(c.nregwe), 32'd0);
        run_instr("j", 6'h02, 6'h00, 1'b0, 0, 0, -1, c);
        check("j_cycles", 32'(c.ncyc), 32'd3);
        run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0, -1, c);
        check("jal_cycles", 32'(c.ncyc), 32'd3);
        check("jal_regwe", 32'(c.nregwe), 32'd1);

        run_instr("ill", 6'h3F, 6'h00, 1'b0, 0, 0, -1, c);
        check("ill_cycles", 32'(c.ncyc), 32'd2);
        check("ill_pulse", 32'(c.nill), 32'd1);
        run_instr("after_ill", 6'h2B, 6'h00, 1'b0, 0, 0, -1, c);

        // Timeouts in FETCH and in memory phases; a short stall afterwards must not time out.
        run_instr("to_fetch", 6'h00, 6'h20, 1'b0, 6, 0, -1, c);
        check("to_fetch_cycles", 32'(c.ncyc), 32'd5);
        check("to_fetch_pulses", 32'(c.nto), 32'd1);
        run_instr("to_restart", 6'h00, 6'h20, 1'b0, 3, 0, -1, c);
        check("to_restart_cycles", 32'(c.ncyc), 32'd7);
        check("to_restart_pulses", 32'(c.nto), 32'd0);
        run_instr("to_memrd", 6'h23, 6'h00, 1'b0, 0, 5, -1, c);
        check("to_memrd_regwe", 32'(c.nregwe), 32'd0);
        check("to_memrd_pulses", 32'(c.nto), 32'd1);
        run_instr("to_memwr", 6'h2B, 6'h00, 1'b0, 0, 4, -1, c);
        check("to_memwr_pulses", 32'(c.nto), 32'd1);

        // Reset inside a MEM_RD wait: abandon the load immediately.
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 0, 3, 5, c);
        mem_ready = 1'b0;
        #2;
        check("mid_pre_state", 32'(state), 32'(S_MEM_RD));
        rst = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'(S_FETCH));
        check("mid_rst_strobes", strobes(), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("mid_rst_strobes_rdy", strobes(), 32'd0);
        @(negedge clk);
        check("mid_rst_hold", strobes(), 32'd0);
        rst = 1'b0;
        run_instr("post_rst", 6'h2B, 6'h00, 1'b0, 0, 0, -1, c);
        check("post_rst_regwe", 32'(c.nregwe), 32'd0);

        // Random programs, including stalls long enough to time out.
        for (int n = 0; n < 200; n++) begin
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            sf = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 6));
            sm = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 6));
            run_instr($sformatf("rnd%0d", n), ops[$urandom_range(0, 14)], fn,
                      1'($urandom_range(0, 1)), sf, sm, -1, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
